// File: rtl/larpix_rx_pkg.sv
// Shared types and helpers for the LArPix PISO lane receiver.
package larpix_rx_pkg;

    localparam int WIDTH_DEFAULT = 64;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    // One buffered packet as seen by a consumer
    typedef struct packed {
        logic        parity_ok;
        logic [63:0] data;
    } rx_entry_t;

    // 1 when the word holds an odd number of ones
    function automatic logic odd_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/larpix_rx_fifo.sv
// Generic first-word-fall-through synchronous FIFO. The head entry is visible
// on o_data whenever o_empty is low. A push into a full FIFO without a
// simultaneous pop is discarded and flagged on o_drop in the same cycle.
// Handshake: a pop takes effect only when i_pop is high and o_empty is low.
module larpix_rx_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic          o_drop,
    output logic [W-1:0]  o_data
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_wr;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_pop   = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_wr    = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & o_full & ~w_pop;
    // Output is forced to zero when empty so nothing stale leaks out
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because occupancy gates the output
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/larpix_piso_rx.sv
// Receiver for one LArPix_v3 PISO UART lane: synchronizes the line, frames
// start / WIDTH data bits (LSB first) / stop, checks odd parity and buffers
// packets in a FWFT FIFO. Consumer handshake: a packet is accepted on any
// cycle where packet_valid and packet_ready are both high; data and parity are
// stable while packet_valid is high and not popped.
module larpix_piso_rx
    import larpix_rx_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int CLK_PER_BIT   = 4,
    parameter int RX_FIFO_DEPTH = 16,
    parameter int CNT_W         = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             piso,
    input  logic                             rx_enable,
    output logic [WIDTH-1:0]                 packet_data,
    output logic                             packet_parity_ok,
    output logic                             packet_valid,
    input  logic                             packet_ready,
    output logic                             frame_err,
    output logic                             busy,
    output logic [$clog2(RX_FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]                 overflow_count,
    output logic [2:0]                       dbg_state
);
    localparam int TMR_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int FCW   = $clog2(RX_FIFO_DEPTH) + 1;
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic             r_sync_meta;
    logic             r_rxs;
    rx_state_t        r_state;
    logic [TMR_W-1:0] r_timer;
    logic [IDX_W-1:0] r_bit_idx;
    logic [WIDTH-1:0] r_shift;
    logic             r_frame_err;
    logic [CNT_W-1:0] r_overflow_count;

    logic             w_stop_sample;
    logic             w_push;
    logic             w_parity_ok;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_drop;
    logic [WIDTH:0]   w_fifo_out;

    // Stop bit is sampled at the same mid-bit point as the data bits
    assign w_stop_sample = rx_enable && (r_state == ST_STOP) && (r_timer == TMR_LAST);
    assign w_push        = w_stop_sample & r_rxs;
    // Zero-extension to 64 bits leaves the parity of the word unchanged
    assign w_parity_ok   = odd_parity(64'(r_shift));

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= 1'b1;
            r_rxs       <= 1'b1;
        end else begin
            r_sync_meta <= piso;
            r_rxs       <= r_sync_meta;
        end
    end

    // Framing FSM with bit timer and data shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (!rx_enable) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_rxs) begin
                            r_state <= ST_START;
                            r_timer <= '0;
                        end
                    end
                    ST_START: begin
                        if (r_timer == TMR_HALF) begin
                            if (r_rxs) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state   <= ST_DATA;
                                r_timer   <= '0;
                                r_bit_idx <= '0;
                            end
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (r_timer == TMR_LAST) begin
                            r_timer            <= '0;
                            r_shift[r_bit_idx] <= r_rxs;
                            if (r_bit_idx == IDX_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + IDX_W'(1);
                            end
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    ST_STOP: begin
                        if (r_timer == TMR_LAST) begin
                            if (r_rxs) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_WAIT_IDLE;
                            end
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (r_rxs) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Saturating count of packets lost to a full buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow_count <= '0;
        end else if (w_fifo_drop && w_fifo_full && (r_overflow_count != '1)) begin
            r_overflow_count <= r_overflow_count + CNT_W'(1);
        end
    end

    larpix_rx_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (RX_FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  ({w_parity_ok, r_shift}),
        .i_pop   (packet_ready),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count),
        .o_drop  (w_fifo_drop),
        .o_data  (w_fifo_out)
    );

    assign packet_valid     = ~w_fifo_empty;
    assign packet_parity_ok = w_fifo_out[WIDTH];
    assign packet_data      = w_fifo_out[WIDTH-1:0];
    assign frame_err        = r_frame_err;
    assign busy             = (r_state != ST_IDLE);
    assign overflow_count   = r_overflow_count;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_larpix_piso_rx.sv
// Directed bench for larpix_piso_rx: drives serial frames on piso, keeps the
// expected packets in a queue and compares them as the FIFO is drained.
module tb_larpix_piso_rx;
    localparam int W     = 64;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int FCW   = $clog2(DEPTH) + 1;
    localparam int BUDGET = 2000;

    logic             clk = 1'b0;
    logic             reset;
    logic             piso;
    logic             rx_enable;
    logic [W-1:0]     packet_data;
    logic             packet_parity_ok;
    logic             packet_valid;
    logic             packet_ready;
    logic             frame_err;
    logic             busy;
    logic [FCW-1:0]   fifo_count;
    logic [CNT_W-1:0] overflow_count;
    logic [2:0]       dbg_state;

    logic [W:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    larpix_piso_rx #(
        .WIDTH         (W),
        .CLK_PER_BIT   (CPB),
        .RX_FIFO_DEPTH (DEPTH),
        .CNT_W         (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .piso             (piso),
        .rx_enable        (rx_enable),
        .packet_data      (packet_data),
        .packet_parity_ok (packet_parity_ok),
        .packet_valid     (packet_valid),
        .packet_ready     (packet_ready),
        .frame_err        (frame_err),
        .busy             (busy),
        .fifo_count       (fifo_count),
        .overflow_count   (overflow_count),
        .dbg_state        (dbg_state)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected entry: odd-parity flag computed from the bench's own bit count
    task automatic exp_push(input logic [W-1:0] v);
        logic p;
        p = (($countones(v) % 2) == 1);
        exp_q.push_back({p, v});
    endtask

    // Called right after a negedge; start bit, nbits data bits LSB first, optional stop
    task automatic send_frame(input logic [W-1:0] v, input int nbits,
                              input logic stop_bit, input bit with_stop);
        piso = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            piso = v[k];
            repeat (CPB) @(negedge clk);
        end
        if (with_stop) begin
            piso = stop_bit;
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Pop n entries with packet_ready held high, comparing each against the queue
    task automatic drain(input int n, input string tag);
        logic [W:0] e;
        packet_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (!packet_valid && t < BUDGET) begin
                @(negedge clk);
                t++;
            end
            check({tag, "_valid"}, 128'(packet_valid), 128'(1));
            if (!packet_valid) break;
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected"}, 128'({packet_parity_ok, packet_data}), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check({tag, "_entry"}, 128'({packet_parity_ok, packet_data}), 128'(e));
            end
            @(negedge clk);
        end
        packet_ready = 1'b0;
    endtask

    // Global time limit so a stuck DUT cannot hang the run
    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v1, v2, v3, v4;
        logic [W:0]   e;
        v1 = 64'h8123_4567_89AB_CDEF;
        v2 = 64'h0123_4567_89AB_CDEF;
        v3 = 64'hDEAD_BEEF_0000_FFFF;
        v4 = {32'h1357_9BDF, 32'($urandom_range(32'hFFFF_FFFE, 1))};

        // Reset idle
        reset = 1'b1;
        piso = 1'b1;
        rx_enable = 1'b1;
        packet_ready = 1'b0;
        repeat (100) @(negedge clk);
        check("rst_valid", 128'(packet_valid), 128'(0));
        check("rst_data", 128'(packet_data), 128'(0));
        check("rst_parity", 128'(packet_parity_ok), 128'(0));
        check("rst_frame_err", 128'(frame_err), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_count", 128'(fifo_count), 128'(0));
        check("rst_overflow", 128'(overflow_count), 128'(0));
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_busy", 128'(busy), 128'(0));

        // Single good packet: valid rises the cycle after the stop sample
        send_frame(v1, W, 1'b1, 1'b1);
        exp_push(v1);
        check("t2_valid_before", 128'(packet_valid), 128'(0));
        @(negedge clk);
        check("t2_valid_rise", 128'(packet_valid), 128'(1));
        check("t2_count1", 128'(fifo_count), 128'(1));
        check("t2_parity", 128'(packet_parity_ok), 128'(1));
        drain(1, "t2");
        check("t2_count0", 128'(fifo_count), 128'(0));

        // Parity error still buffers intact data
        repeat (3) @(negedge clk);
        send_frame(v2, W, 1'b1, 1'b1);
        exp_push(v2);
        repeat (2) @(negedge clk);
        check("t3_parity", 128'(packet_parity_ok), 128'(0));
        drain(1, "t3");

        // One-cycle glitch is seen, then rejected
        piso = 1'b0;
        @(negedge clk);
        piso = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_glitch_busy", 128'(busy), 128'(1));
        repeat (5) @(negedge clk);
        check("t3_glitch_idle", 128'(busy), 128'(0));
        check("t3_glitch_count", 128'(fifo_count), 128'(0));

        // Framing error: single pulse, no push, then recovery
        send_frame(v3, W, 1'b0, 1'b1);
        check("t4_ferr_before", 128'(frame_err), 128'(0));
        piso = 1'b1;
        @(negedge clk);
        check("t4_ferr_pulse", 128'(frame_err), 128'(1));
        @(negedge clk);
        check("t4_ferr_after", 128'(frame_err), 128'(0));
        check("t4_no_push", 128'(fifo_count), 128'(0));
        repeat (8) @(negedge clk);
        check("t4_busy", 128'(busy), 128'(0));
        send_frame(v4, W, 1'b1, 1'b1);
        exp_push(v4);
        drain(1, "t4");

        // Overflow: 18 back-to-back packets, last two dropped
        repeat (3) @(negedge clk);
        for (int v = 1; v <= 18; v++) begin
            send_frame(64'(v), W, 1'b1, 1'b1);
            if (v <= DEPTH) exp_push(64'(v));
        end
        @(negedge clk);
        check("t5_count_full", 128'(fifo_count), 128'(16));
        check("t5_overflow", 128'(overflow_count), 128'(2));
        drain(16, "t5");
        check("t5_drained", 128'(fifo_count), 128'(0));

        // Full FIFO with pop in the push cycle: nothing dropped
        for (int v = 1; v <= 17; v++) begin
            send_frame(64'(v), W, 1'b1, 1'b1);
            exp_push(64'(v));
        end
        // 17th stop sample happens at the next edge; pop the head at that edge
        packet_ready = 1'b1;
        e = exp_q.pop_front();
        check("t5b_head", 128'({packet_parity_ok, packet_data}), 128'(e));
        @(negedge clk);
        packet_ready = 1'b0;
        check("t5b_count", 128'(fifo_count), 128'(16));
        check("t5b_overflow", 128'(overflow_count), 128'(2));
        drain(16, "t5b");
        check("t5b_drained", 128'(fifo_count), 128'(0));

        // Reset mid-DATA empties the FIFO and discards the partial packet
        repeat (3) @(negedge clk);
        send_frame(v1, W, 1'b1, 1'b1);
        send_frame(v2, 20, 1'b1, 1'b0);
        piso = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("t6_rst_count", 128'(fifo_count), 128'(0));
        check("t6_rst_valid", 128'(packet_valid), 128'(0));
        check("t6_rst_busy", 128'(busy), 128'(0));
        check("t6_rst_overflow", 128'(overflow_count), 128'(0));
        repeat (4) @(negedge clk);
        send_frame(v4, W, 1'b1, 1'b1);
        exp_push(v4);
        drain(1, "t6_rst");

        // rx_enable drop mid-DATA keeps the FIFO untouched
        repeat (3) @(negedge clk);
        send_frame(v1, W, 1'b1, 1'b1);
        exp_push(v1);
        send_frame(v2, 30, 1'b1, 1'b0);
        rx_enable = 1'b0;
        piso = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_en_busy", 128'(busy), 128'(0));
        check("t6_en_count", 128'(fifo_count), 128'(1));
        rx_enable = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(v3, W, 1'b1, 1'b1);
        exp_push(v3);
        drain(2, "t6_en");
        check("t6_en_drained", 128'(fifo_count), 128'(0));
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
